imm_extend_pipe: RTL and testbench
==================================

// Module: imm_extend_pipe
// PURPOSE
//  Parametrised, pipelined immediate-extension stage for the datapath decode path.
//  Takes an IN_W-bit immediate plus a mode and produces an OUT_W-bit operand:
//  sign-extend, zero-extend, LUI upper placement, or branch offset (sign-extend << BR_SH).
//  One-cycle registered latency, valid/ready on both sides, 2-entry skid for full throughput, flush.
// PARAMETERS
//  IN_W   16  immediate input width (>=2)
//  OUT_W  32  extended output width (must be >= IN_W + BR_SH)
//  BR_SH  2   left-shift amount for branch-offset mode
//  TAG_W  5   width of sideband tag carried alongside each immediate (e.g. dest reg)
// PORTS
//  clk        in   1      clock, rising edge
//  reset      in   1      asynchronous, active-high reset
//  flush      in   1      sync: discard all held entries
//  in_valid   in   1      input immediate valid
//  in_ready   out  1      stage can accept this cycle
//  in_imm     in   IN_W   raw immediate
//  in_mode    in   2      00 SEXT, 01 ZEXT, 10 LUI, 11 BROFF
//  in_tag     in   TAG_W  sideband, returned unchanged
//  out_valid  out  1      output valid
//  out_ready  in   1      consumer accepts
//  out_imm    out  OUT_W  extended immediate
//  out_tag    out  TAG_W  tag of the entry on out_imm
//  out_neg    out  1      MSB of out_imm
// BEHAVIOUR
//  Reset (async, immediate): out_valid=0, skid_valid=0, out_imm=0, out_tag=0, out_neg=0, in_ready=1.
//  Arithmetic (combinational, before the output register), X=in_imm:
//   SEXT : {{(OUT_W-IN_W){X[IN_W-1]}}, X}
//   ZEXT : {{(OUT_W-IN_W){1'b0}}, X}
//   LUI  : X << (OUT_W-IN_W); low OUT_W-IN_W bits zero (OUT_W==IN_W => pass X)
//   BROFF: SEXT(X) << BR_SH; MSBs shifted out are dropped, low BR_SH bits zero
//  Handshake: in xfer = in_valid & in_ready; out xfer = out_valid & out_ready.
//   in_ready = ~skid_valid (driven from a flop, no comb path from out_ready).
//   Latency: in xfer at edge N -> out_valid=1 with result after edge N.
//   Out reg empty or draining (out xfer): accepted item goes straight to out reg.
//   Out reg full and stalled: accepted item goes to skid; in_ready drops next cycle.
//   Skid full and out xfer: skid moves to out reg, skid_valid=0, in_ready=1 next cycle.
//   Sustained in_valid & out_ready: one item per cycle, no bubbles.
//   out_imm/out_tag/out_neg stable while out_valid & ~out_ready (no change under stall).
//   Order strictly FIFO; no item dropped or duplicated except by flush/reset.
//  Flush: clears out_valid and skid_valid at the edge; an in xfer in the same cycle is
//   discarded (flush wins). Data regs may hold stale values; out_valid=0 after flush.
//  Reset mid-transfer: all held items lost, no partial output.
//  in_mode sampled only on in xfer; value ignored when in_valid=0.
// STRUCTURE
//  Package imm_ext_pkg: localparams MODE_SEXT=2'b00, MODE_ZEXT=2'b01, MODE_LUI=2'b10,
//   MODE_BROFF=2'b11; function/typedef for the 2-bit mode.
//  Sub-module imm_ext_core (pure combinational, params IN_W/OUT_W/BR_SH): mode mux + shifts.
//  Top: imm_ext_core + output register + skid register + valid/ready control.
// TESTING
//  Defaults. SEXT 16'h000A -> 32'h0000000A, out_neg=0; SEXT 16'h8000 -> 32'hFFFF8000, out_neg=1.
//  ZEXT 16'hFFFA -> 32'h0000FFFA; LUI 16'h1234 -> 32'h12340000; BROFF 16'hFFFF -> 32'hFFFFFFFC,
//   BROFF 16'h7FFF -> 32'h0001FFFC.
//  Back-to-back 8 items, out_ready=1 -> 8 outputs on consecutive cycles, order and tags kept.
//  out_ready=0 for 3 cycles with in_valid=1 -> 2 accepted, in_ready=0, out_imm stable;
//   release -> both drained in order, in_ready returns 1.
//  flush with out+skid full and in_valid=1 -> next cycle out_valid=0, in_ready=1, nothing emitted.
//  Assert reset async mid-stream -> out_valid=0, out_imm=0 immediately; IN_W=8,OUT_W=16 SEXT 8'h80 -> 16'hFF80.

Source files
------------

// File: rtl/imm_ext_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_ext_pkg
// Description : Shared mode encodings and helpers for the immediate-extension stage.
// Revision    : 1.0 - initial release
// ============================================================================
package imm_ext_pkg;

    typedef logic [1:0] imm_mode_t;

    localparam imm_mode_t MODE_SEXT  = 2'b00;
    localparam imm_mode_t MODE_ZEXT  = 2'b01;
    localparam imm_mode_t MODE_LUI   = 2'b10;
    localparam imm_mode_t MODE_BROFF = 2'b11;

    // Branch offsets are signed displacements, so they share the sign-extended base.
    function automatic logic mode_is_signed(input imm_mode_t mode);
        return (mode == MODE_SEXT) || (mode == MODE_BROFF);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imm_ext_core.sv
`default_nettype none
// ============================================================================
// Module      : imm_ext_core
// Description : Combinational immediate extender: SEXT, ZEXT, LUI, branch offset.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int BR_SH = 2
) (
    input  logic [IN_W-1:0]  imm_i,
    input  imm_mode_t        mode_i,
    output logic [OUT_W-1:0] ext_o
);

    logic [OUT_W-1:0] w_zext;
    logic [OUT_W-1:0] w_sext;
    logic [OUT_W-1:0] w_base;

    assign w_zext = OUT_W'(imm_i);
    assign w_sext = OUT_W'($signed(imm_i));
    assign w_base = mode_is_signed(mode_i) ? w_sext : w_zext;

    // Shift form keeps the OUT_W == IN_W case legal (zero-distance LUI shift).
    always_comb begin
        ext_o = w_base;
        case (mode_i)
            MODE_LUI:   ext_o = w_zext << (OUT_W - IN_W);
            MODE_BROFF: ext_o = w_sext << BR_SH;
            default:    ext_o = w_base;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_extend_pipe
// Description : Registered immediate-extension stage with valid/ready, skid and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int BR_SH = 2,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  imm_mode_t        in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_neg
);

    logic [OUT_W-1:0] w_ext;
    logic             w_in_xfer;
    logic             w_out_xfer;

    logic             out_valid_q,  out_valid_d;
    logic [OUT_W-1:0] out_imm_q,    out_imm_d;
    logic [TAG_W-1:0] out_tag_q,    out_tag_d;
    logic             skid_valid_q, skid_valid_d;
    logic [OUT_W-1:0] skid_imm_q,   skid_imm_d;
    logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .BR_SH (BR_SH)
    ) u_core (
        .imm_i  (in_imm),
        .mode_i (in_mode),
        .ext_o  (w_ext)
    );

    assign in_ready   = ~skid_valid_q;
    assign w_in_xfer  = in_valid & in_ready & ~flush;
    assign w_out_xfer = out_valid_q & out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_imm_d    = out_imm_q;
        out_tag_d    = out_tag_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_tag_d   = skid_tag_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            // in_ready is low here, so only the drain path can fire.
            if (w_out_xfer) begin
                out_imm_d    = skid_imm_q;
                out_tag_d    = skid_tag_q;
                skid_valid_d = 1'b0;
            end
        end else if (w_in_xfer) begin
            if (!out_valid_q || w_out_xfer) begin
                out_valid_d = 1'b1;
                out_imm_d   = w_ext;
                out_tag_d   = in_tag;
            end else begin
                skid_valid_d = 1'b1;
                skid_imm_d   = w_ext;
                skid_tag_d   = in_tag;
            end
        end else if (w_out_xfer) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_tag_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_tag_q   <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_imm_q    <= out_imm_d;
            out_tag_q    <= out_tag_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_tag_q   <= skid_tag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_imm   = out_imm_q;
    assign out_tag   = out_tag_q;
    assign out_neg   = out_imm_q[OUT_W-1];

endmodule
`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_extend_pipe
// Description : Directed self-checking bench for imm_extend_pipe (default and 8->16 builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [1:0]  in_mode;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic [4:0]  out_tag;
    logic        out_neg;

    logic        flush8;
    logic        in8_valid;
    logic        in8_ready;
    logic [7:0]  in8_imm;
    logic [1:0]  in8_mode;
    logic [4:0]  in8_tag;
    logic        out8_valid;
    logic        out8_ready;
    logic [15:0] out8_imm;
    logic [4:0]  out8_tag;
    logic        out8_neg;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    imm_extend_pipe dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm),
        .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_tag(out_tag), .out_neg(out_neg)
    );

    imm_extend_pipe #(.IN_W(8), .OUT_W(16), .BR_SH(2), .TAG_W(5)) dut8 (
        .clk(clk), .reset(reset), .flush(flush8),
        .in_valid(in8_valid), .in_ready(in8_ready), .in_imm(in8_imm),
        .in_mode(in8_mode), .in_tag(in8_tag),
        .out_valid(out8_valid), .out_ready(out8_ready), .out_imm(out8_imm),
        .out_tag(out8_tag), .out_neg(out8_neg)
    );

    task automatic test_reset();
        #2;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (out_imm !== 32'h0) begin bad++; $display("FAIL reset_out_imm got=%h exp=0", out_imm); end
        total++; if (out_tag !== 5'h0) begin bad++; $display("FAIL reset_out_tag got=%h exp=0", out_tag); end
        total++; if (out_neg !== 1'b0) begin bad++; $display("FAIL reset_out_neg got=%b exp=0", out_neg); end
        total++; if (out8_valid !== 1'b0) begin bad++; $display("FAIL reset_out8_valid got=%b exp=0", out8_valid); end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_modes();
        logic [15:0] v_imm [6];
        logic [1:0]  v_mode[6];
        logic [31:0] v_exp [6];
        logic        v_neg [6];
        v_imm[0] = 16'h000A; v_mode[0] = 2'b00; v_exp[0] = 32'h0000000A; v_neg[0] = 1'b0;
        v_imm[1] = 16'h8000; v_mode[1] = 2'b00; v_exp[1] = 32'hFFFF8000; v_neg[1] = 1'b1;
        v_imm[2] = 16'hFFFA; v_mode[2] = 2'b01; v_exp[2] = 32'h0000FFFA; v_neg[2] = 1'b0;
        v_imm[3] = 16'h1234; v_mode[3] = 2'b10; v_exp[3] = 32'h12340000; v_neg[3] = 1'b0;
        v_imm[4] = 16'hFFFF; v_mode[4] = 2'b11; v_exp[4] = 32'hFFFFFFFC; v_neg[4] = 1'b1;
        v_imm[5] = 16'h7FFF; v_mode[5] = 2'b11; v_exp[5] = 32'h0001FFFC; v_neg[5] = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_imm = v_imm[i]; in_mode = v_mode[i]; in_tag = 5'(i + 10);
            @(posedge clk); #1;
            in_valid = 1'b0; in_mode = 2'b11;
            total++; if (out_valid !== 1'b1 || out_imm !== v_exp[i])
                begin bad++; $display("FAIL mode_vec%0d got v=%b imm=%h exp v=1 imm=%h", i, out_valid, out_imm, v_exp[i]); end
            total++; if (out_neg !== v_neg[i] || out_tag !== 5'(i + 10))
                begin bad++; $display("FAIL mode_neg_tag%0d got neg=%b tag=%0d exp neg=%b tag=%0d", i, out_neg, out_tag, v_neg[i], i + 10); end
        end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mode_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1; in_imm = 16'(k * 257); in_mode = 2'b01; in_tag = 5'(k + 3);
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b1 || out_imm !== {16'h0, 16'(k * 257)} || out_tag !== 5'(k + 3) || in_ready !== 1'b1)
                begin bad++; $display("FAIL b2b_item%0d got v=%b imm=%h tag=%0d rdy=%b exp v=1 imm=%h tag=%0d rdy=1",
                                      k, out_valid, out_imm, out_tag, in_ready, {16'h0, 16'(k * 257)}, k + 3); end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_tail got=%b exp=0", out_valid); end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        in_valid = 1'b1; in_imm = 16'h0011; in_mode = 2'b00; in_tag = 5'd1;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b1 || out_imm !== 32'h00000011 || in_ready !== 1'b1)
            begin bad++; $display("FAIL stall_c1 got v=%b imm=%h rdy=%b exp v=1 imm=00000011 rdy=1", out_valid, out_imm, in_ready); end
        in_imm = 16'h0022; in_tag = 5'd2;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b0 || out_imm !== 32'h00000011 || out_tag !== 5'd1)
            begin bad++; $display("FAIL stall_c2 got rdy=%b imm=%h tag=%0d exp rdy=0 imm=00000011 tag=1", in_ready, out_imm, out_tag); end
        in_imm = 16'h0033; in_tag = 5'd3;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b0 || out_imm !== 32'h00000011 || out_valid !== 1'b1)
            begin bad++; $display("FAIL stall_c3 got rdy=%b imm=%h v=%b exp rdy=0 imm=00000011 v=1", in_ready, out_imm, out_valid); end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b1 || out_imm !== 32'h00000022 || out_tag !== 5'd2 || in_ready !== 1'b1)
            begin bad++; $display("FAIL stall_drain got v=%b imm=%h tag=%0d rdy=%b exp v=1 imm=00000022 tag=2 rdy=1",
                                  out_valid, out_imm, out_tag, in_ready); end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_imm = 16'h0101; in_mode = 2'b01; in_tag = 5'd4;
        @(posedge clk); #1;
        in_imm = 16'h0202; in_tag = 5'd5;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b0 || out_valid !== 1'b1)
            begin bad++; $display("FAIL flush_fill got rdy=%b v=%b exp rdy=0 v=1", in_ready, out_valid); end
        flush = 1'b1; in_imm = 16'h0303; in_tag = 5'd6;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin bad++; $display("FAIL flush_clear got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_nothing got v=%b exp=0", out_valid); end
        // flush must also win over an input offered while the stage is empty
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_wins got v=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_async();
        out_ready = 1'b0;
        in_valid = 1'b1; in_imm = 16'h5555; in_mode = 2'b01; in_tag = 5'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_imm !== 32'h00005555)
            begin bad++; $display("FAIL arst_pre got v=%b imm=%h exp v=1 imm=00005555", out_valid, out_imm); end
        #2 reset = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0 || out_imm !== 32'h0 || in_ready !== 1'b1)
            begin bad++; $display("FAIL arst_now got v=%b imm=%h rdy=%b exp v=0 imm=0 rdy=1", out_valid, out_imm, in_ready); end
        @(posedge clk); #1;
        reset = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_after got v=%b exp=0", out_valid); end
    endtask

    task automatic test_narrow();
        out8_ready = 1'b1;
        in8_valid = 1'b1; in8_imm = 8'h80; in8_mode = 2'b00; in8_tag = 5'd9;
        @(posedge clk); #1;
        total++; if (out8_valid !== 1'b1 || out8_imm !== 16'hFF80 || out8_neg !== 1'b1)
            begin bad++; $display("FAIL narrow_sext got v=%b imm=%h neg=%b exp v=1 imm=ff80 neg=1", out8_valid, out8_imm, out8_neg); end
        in8_imm = 8'hAB; in8_mode = 2'b10;
        @(posedge clk); #1;
        total++; if (out8_imm !== 16'hAB00) begin bad++; $display("FAIL narrow_lui got=%h exp=ab00", out8_imm); end
        in8_imm = 8'hC1; in8_mode = 2'b11;
        @(posedge clk); #1;
        in8_valid = 1'b0;
        total++; if (out8_imm !== 16'hFF04 || out8_tag !== 5'd9)
            begin bad++; $display("FAIL narrow_broff got imm=%h tag=%0d exp imm=ff04 tag=9", out8_imm, out8_tag); end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_imm = '0; in_mode = '0; in_tag = '0; out_ready = 1'b1;
        flush8 = 1'b0; in8_valid = 1'b0; in8_imm = '0; in8_mode = '0; in8_tag = '0; out8_ready = 1'b1;
        test_reset();
        test_modes();
        test_back_to_back();
        test_stall();
        test_flush();
        test_reset_async();
        test_narrow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
